blink_rate_ctrl: RTL and testbench
==================================

# blink_rate_ctrl

Upstream timing source for the board's LED flasher, on a 50 MHz clock. Debounces the raw pushbutton and steps through four blink rates on each accepted press. Emits a one-cycle `tick` at every LED half-period, and the flasher toggles its LED on each tick. Replaces the flasher's fixed free-running divider with a user-selectable rate.

## Interface
- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles required to accept a button level change (20 ms).
- `RATE0`, 2_500_000: tick period in cycles when `rate_sel`=0.
- `RATE1`, 5_000_000: tick period for `rate_sel`=1.
- `RATE2`, 12_500_000: tick period for `rate_sel`=2.
- `RATE3`, 25_000_000: tick period for `rate_sel`=3.
- `HOLD_CYC`, 50_000_000: long-press threshold in cycles (1 s). Used only with `BLINK_PAUSE_EN`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn_in` in 1: raw, asynchronous, bouncing pushbutton, active-high.
- `tick` out 1: one-cycle pulse per half-period.
- `rate_sel` out 2: current rate index.
- `btn_pulse` out 1: one-cycle pulse per accepted press.
- `paused` out 1: tick suppression active. Tied 0 without `BLINK_PAUSE_EN`.

## Operation
- **Synchronizer:** `btn_in` passes through a 2-FF synchronizer, reset to 0, giving `btn_s`.
- **Debounce FSM states:**
  - STABLE_LO → WAIT_HI when `btn_s`=1.
  - WAIT_HI → STABLE_LO when `btn_s`=0; the counter clears.
  - WAIT_HI → STABLE_HI when `btn_s` has been 1 for `DEBOUNCE_CYC` consecutive cycles. This transition is the accepted press.
  - STABLE_HI → WAIT_LO when `btn_s`=0; WAIT_LO mirrors WAIT_HI.
  - WAIT_LO → STABLE_LO when `btn_s` has been 0 for `DEBOUNCE_CYC` consecutive cycles. This transition is the accepted release.
- **Debounce counter:** width is `$clog2(DEBOUNCE_CYC+1)`. It never wraps. Any bounce inside a WAIT state restarts qualification from zero.
- **Accepted press:** `btn_pulse`=1 for exactly one cycle. `rate_sel` increments modulo 4 (3 → 0).
- **Tick counter:** width is `$clog2` of the largest RATE. It counts 0..RATEn−1. At RATEn−1 it asserts `tick` that cycle and reloads 0. Every RATEn ≥ 2.
- **Rate change:** in the cycle `rate_sel` updates, the tick counter clears to 0. The new period starts from 0.
- **Simultaneous rate change and terminal count:** the rate change wins. No tick that cycle.
- **Reset:** assertion mid-operation immediately returns all state to reset values. No tick or pulse is emitted during or on exit from reset.
- **Reset values:** `tick`=0, `btn_pulse`=0, `rate_sel`=0, `paused`=0, FSM=STABLE_LO, all counters=0.

## Timing
- All outputs are registered.
- **Press latency:** `btn_in` held high from the clock edge at which it is first sampled 1. `btn_pulse` and the new `rate_sel` appear DEBOUNCE_CYC+2 cycles later.
- **Tick spacing:** consecutive ticks are exactly RATEn cycles apart at a constant rate.
- **First tick after reset or rate change:** arrives RATEn cycles after the clear.
- `btn_pulse` and `tick` never stay high for two consecutive cycles.

## Configuration
- **`BLINK_PAUSE_EN` defined:**
  - The rate advance moves from the accepted press to the accepted release, and occurs only if press duration < `HOLD_CYC`.
  - Press duration is counted in STABLE_HI, and saturates.
  - When duration reaches `HOLD_CYC` while in STABLE_HI, `paused` toggles in that cycle and `btn_pulse` fires.
  - A release following a hold does not advance the rate.
  - While `paused`=1, the tick counter holds its value and `tick`=0.
  - On unpause, counting resumes from the held value.
- **`BLINK_PAUSE_EN` undefined:** behaviour as in Operation. `paused` is constant 0 and there is no hold counter.

## Structure
- **Shared package `blink_pkg`:** default rate constants, the `debounce_state_t` enum (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO), and the 50 MHz clock constant.
- **Sub-module `btn_debounce`:** synchronizer plus FSM. Outputs the level, `press`, and `release` pulses.
- **Top level:** `blink_rate_ctrl` holds `rate_sel`, the tick counter, and the pause logic.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, RATE0..3=3,5,7,9, and `HOLD_CYC`=10.
- **Reset state:** release `rst` with no button activity → `tick` every 3 cycles, first tick 3 cycles after reset release; `rate_sel`=0 throughout.
- **Clean press:** `btn_in` high 20 cycles → `btn_pulse` 6 cycles after the first sample; `rate_sel`=1; ticks then 5 cycles apart, starting from a cleared counter.
- **Bounce rejection:** `btn_in` toggled 1,0,1,0 every 2 cycles, then steady low → no `btn_pulse`, `rate_sel` unchanged.
- **Wrap:** four accepted presses → `rate_sel` sequence 1,2,3,0; tick spacing 5,7,9,3.
- **Collision:** time a press so `rate_sel` updates in the terminal-count cycle → no tick that cycle; next tick RATE cycles later.
- **Pause (`BLINK_PAUSE_EN`):**
  - Hold 30 cycles → `paused`=1 once the press duration reaches 10 cycles, ticks stop, release does not change `rate_sel`.
  - A subsequent 6-cycle press → `paused` stays 1 and `rate_sel` advances on release.
  - Reset during pause → `paused`=0.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared constants and debounce state encoding for the LED blink-rate controller.
package blink_pkg;
    localparam int unsigned CLK_HZ           = 50_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int unsigned DEF_RATE0        = 2_500_000;
    localparam int unsigned DEF_RATE1        = 5_000_000;
    localparam int unsigned DEF_RATE2        = 12_500_000;
    localparam int unsigned DEF_RATE3        = 25_000_000;
    localparam int unsigned DEF_HOLD_CYC     = CLK_HZ;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } debounce_state_t;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer and four-state debounce FSM; emits debounced level plus
// one-cycle press/release strobes in the cycle the FSM accepts the change.
module btn_debounce
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic stable_hi,
    output logic press_p,
    output logic release_p
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic            sync1_q, btn_s_q;
    debounce_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_in;
            btn_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter only advances inside a WAIT state; every other path clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            STABLE_LO: if (btn_s_q) state_d = WAIT_HI;
            WAIT_HI: begin
                if (!btn_s_q)               state_d = STABLE_LO;
                else if (cnt_q == CNT_LAST) state_d = STABLE_HI;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            STABLE_HI: if (!btn_s_q) state_d = WAIT_LO;
            WAIT_LO: begin
                if (btn_s_q)                state_d = STABLE_HI;
                else if (cnt_q == CNT_LAST) state_d = STABLE_LO;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = STABLE_LO;
        endcase
    end

    always_comb begin
        level     = (state_q == STABLE_HI) || (state_q == WAIT_LO);
        stable_hi = (state_q == STABLE_HI);
        press_p   = (state_q == WAIT_HI) && btn_s_q && (cnt_q == CNT_LAST);
        release_p = (state_q == WAIT_LO) && !btn_s_q && (cnt_q == CNT_LAST);
    end
endmodule

// File: rtl/blink_rate_ctrl.sv
// Button-selected blink-rate tick generator. Optional long-press pause is built
// when BLINK_PAUSE_EN is defined.
module blink_rate_ctrl
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned RATE0        = DEF_RATE0,
    parameter int unsigned RATE1        = DEF_RATE1,
    parameter int unsigned RATE2        = DEF_RATE2,
    parameter int unsigned RATE3        = DEF_RATE3,
    parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       tick,
    output logic [1:0] rate_sel,
    output logic       btn_pulse,
    output logic       paused
);
    localparam int unsigned RATE_MAX = max4(RATE0, RATE1, RATE2, RATE3);
    localparam int TW = $clog2(RATE_MAX);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    rate_sel_q, rate_sel_d;
    logic          tick_q, tick_d;
    logic          btn_pulse_q, btn_pulse_d;
    logic          db_level, db_stable_hi, db_press, db_release;
    logic          advance, pause_act, hold_hit;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .level     (db_level),
        .stable_hi (db_stable_hi),
        .press_p   (db_press),
        .release_p (db_release)
    );

    function automatic logic [TW-1:0] rate_last(input logic [1:0] sel);
        case (sel)
            2'd0:    rate_last = TW'(RATE0 - 1);
            2'd1:    rate_last = TW'(RATE1 - 1);
            2'd2:    rate_last = TW'(RATE2 - 1);
            default: rate_last = TW'(RATE3 - 1);
        endcase
    endfunction

`ifdef BLINK_PAUSE_EN
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_FULL = HW'(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          paused_q, paused_d;
    logic          unused_level;

    assign unused_level = db_level;

    // Duration saturates at HOLD_CYC so a held button toggles pause exactly once.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        paused_d   = paused_q;
        hold_hit   = 1'b0;
        if (db_press) begin
            hold_cnt_d = '0;
        end else if (db_stable_hi && (hold_cnt_q != HOLD_FULL)) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            if (hold_cnt_q == HOLD_LAST) begin
                hold_hit = 1'b1;
                paused_d = ~paused_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
            paused_q   <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            paused_q   <= paused_d;
        end
    end

    assign advance   = db_release && (hold_cnt_q != HOLD_FULL);
    assign pause_act = paused_q;
    assign paused    = paused_q;
`else
    localparam int unsigned unused_hold = HOLD_CYC;
    logic unused_db;

    assign unused_db = ^{db_level, db_stable_hi, db_release};
    assign advance   = db_press;
    assign pause_act = 1'b0;
    assign hold_hit  = 1'b0;
    assign paused    = 1'b0;
`endif

    // A rate change outranks a coincident terminal count: no tick, counter restarts.
    always_comb begin
        rate_sel_d  = rate_sel_q;
        tick_cnt_d  = tick_cnt_q;
        tick_d      = 1'b0;
        btn_pulse_d = db_press | hold_hit;
        if (advance) begin
            rate_sel_d = rate_sel_q + 2'd1;
            tick_cnt_d = '0;
        end else if (pause_act) begin
            tick_cnt_d = tick_cnt_q;
        end else if (tick_cnt_q == rate_last(rate_sel_q)) begin
            tick_d     = 1'b1;
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            rate_sel_q  <= 2'd0;
            tick_q      <= 1'b0;
            btn_pulse_q <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            rate_sel_q  <= rate_sel_d;
            tick_q      <= tick_d;
            btn_pulse_q <= btn_pulse_d;
        end
    end

    assign tick      = tick_q;
    assign rate_sel  = rate_sel_q;
    assign btn_pulse = btn_pulse_q;
endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Self-checking bench for blink_rate_ctrl with shrunk timing constants; directed
// scenarios plus randomized button activity against a run-length reference model.
module tb_blink_rate_ctrl;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RATES [4] = '{3, 5, 7, 9};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       tick, btn_pulse, paused;
    logic [1:0] rate_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blink_rate_ctrl #(
        .DEBOUNCE_CYC(DB), .RATE0(3), .RATE1(5), .RATE2(7), .RATE3(9), .HOLD_CYC(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .tick(tick), .rate_sel(rate_sel), .btn_pulse(btn_pulse), .paused(paused)
    );

    // Reference: btn_s is btn_in two samples late; a level change is accepted once
    // btn_s has differed from the debounced level for DB+1 consecutive samples.
    bit m_s1, m_s2, m_lvl, m_tick, m_pulse, m_acc;
    int m_run, m_rate, m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
            m_rate = 0; m_cnt = 0; m_tick = 0; m_pulse = 0;
        end else begin
            m_acc = 0;
            if (m_s2 != m_lvl) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_acc = 1; m_lvl = ~m_lvl; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
            m_pulse = m_acc && m_lvl;
            if (m_pulse) begin
                m_rate = (m_rate + 1) % 4; m_cnt = 0; m_tick = 0;
            end else if (m_cnt == RATES[m_rate] - 1) begin
                m_tick = 1; m_cnt = 0;
            end else begin
                m_cnt++; m_tick = 0;
            end
        end
    end

    task automatic wait_tick(output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (tick) begin n = k; break; end
        end
    endtask

    task automatic wait_pulse(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (btn_pulse) begin n = k; break; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; btn_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tick, btn_pulse, rate_sel, paused} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 00000", {tick, btn_pulse, rate_sel, paused});
        end
        rst = 1'b0;
        wait_tick(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL reset_first_tick: got %0d expected 3", n); end
        wait_tick(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL reset_tick_spacing: got %0d expected 3", n); end
        checks++;
        if (rate_sel !== 2'd0) begin errors++; $display("FAIL reset_rate: got %0d expected 0", rate_sel); end
    endtask

    task automatic test_clean_press();
        int n;
        btn_in = 1'b1;
        wait_pulse(n);
        checks++;
        if (n - 1 !== DB + 2) begin errors++; $display("FAIL press_latency: got %0d expected %0d", n - 1, DB + 2); end
        checks++;
        if (rate_sel !== 2'd1) begin errors++; $display("FAIL press_rate: got %0d expected 1", rate_sel); end
        wait_tick(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL press_first_tick: got %0d expected 5", n); end
        wait_tick(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL press_tick_spacing: got %0d expected 5", n); end
        repeat (4) @(negedge clk);
        btn_in = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (rate_sel !== 2'd1) begin errors++; $display("FAIL release_rate: got %0d expected 1", rate_sel); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        logic [1:0] r0;
        r0 = rate_sel;
        for (int i = 0; i < 4; i++) begin
            btn_in = (i % 2 == 0);
            repeat (2) begin @(negedge clk); if (btn_pulse) pulses++; end
        end
        btn_in = 1'b0;
        repeat (20) begin @(negedge clk); if (btn_pulse) pulses++; end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d expected 0", pulses); end
        checks++;
        if (rate_sel !== r0) begin errors++; $display("FAIL bounce_rate: got %0d expected %0d", rate_sel, r0); end
    endtask

    task automatic test_wrap();
        int n, exp_r;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_r = (i + 1) % 4;
            btn_in = 1'b1;
            wait_pulse(n);
            checks++;
            if (rate_sel !== exp_r[1:0] || rate_sel !== m_rate[1:0]) begin
                errors++; $display("FAIL wrap_rate_%0d: got %0d expected %0d", i, rate_sel, exp_r);
            end
            wait_tick(n);
            checks++;
            if (n !== RATES[exp_r]) begin errors++; $display("FAIL wrap_first_tick_%0d: got %0d expected %0d", i, n, RATES[exp_r]); end
            wait_tick(n);
            checks++;
            if (n !== RATES[exp_r]) begin errors++; $display("FAIL wrap_spacing_%0d: got %0d expected %0d", i, n, RATES[exp_r]); end
            btn_in = 1'b0;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic test_collision();
        int n;
        do_reset();
        wait_tick(n);
        repeat (2) @(negedge clk);
        btn_in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (tick !== 1'b1) begin errors++; $display("FAIL collision_phase: tick got %b expected 1", tick); end
            end
            if (k == 7) begin
                checks++;
                if (btn_pulse !== 1'b1) begin errors++; $display("FAIL collision_pulse: got %b expected 1", btn_pulse); end
                checks++;
                if (tick !== 1'b0) begin errors++; $display("FAIL collision_tick: got %b expected 0", tick); end
            end
        end
        wait_tick(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL collision_next_tick: got %0d expected 5", n); end
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        int total = 0;
        int len;
        bit prev_tick = 0, prev_pulse = 0;
        do_reset();
        while (total < 3000) begin
            btn_in = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 15);
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                total++;
                checks++;
                if ({tick, btn_pulse, rate_sel} !== {m_tick, m_pulse, m_rate[1:0]}) begin
                    errors++;
                    $display("FAIL random_cycle_%0d: got tick=%b pulse=%b rate=%0d expected tick=%b pulse=%b rate=%0d",
                             total, tick, btn_pulse, rate_sel, m_tick, m_pulse, m_rate);
                end
                if ((prev_tick && tick) || (prev_pulse && btn_pulse)) begin
                    errors++; $display("FAIL random_double_pulse_%0d: got tick=%b pulse=%b expected single-cycle", total, tick, btn_pulse);
                end
                prev_tick = tick; prev_pulse = btn_pulse;
            end
        end
        btn_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        btn_in = 1'b1;
        wait_pulse(n);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1; btn_in = 1'b0;
        #1;
        checks++;
        if ({tick, btn_pulse, rate_sel, paused} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_outputs: got %b expected 00000", {tick, btn_pulse, rate_sel, paused});
        end
        @(negedge clk);
        rst = 1'b0;
        wait_tick(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL reset_mid_first_tick: got %0d expected 3", n); end
        checks++;
        if (rate_sel !== 2'd0) begin errors++; $display("FAIL reset_mid_rate: got %0d expected 0", rate_sel); end
    endtask

`ifdef BLINK_PAUSE_EN
    task automatic test_pause();
        int ticks = 0;
        do_reset();
        btn_in = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 20) begin
                checks++;
                if (paused !== 1'b1) begin errors++; $display("FAIL pause_set: got %b expected 1", paused); end
            end
            if (k > 20 && tick) ticks++;
        end
        btn_in = 1'b0;
        repeat (15) begin @(negedge clk); if (tick) ticks++; end
        checks++;
        if (ticks !== 0) begin errors++; $display("FAIL pause_ticks: got %0d expected 0", ticks); end
        checks++;
        if (rate_sel !== 2'd0) begin errors++; $display("FAIL pause_hold_rate: got %0d expected 0", rate_sel); end
        btn_in = 1'b1;
        repeat (6) @(negedge clk);
        btn_in = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (rate_sel !== 2'd1) begin errors++; $display("FAIL pause_short_rate: got %0d expected 1", rate_sel); end
        checks++;
        if (paused !== 1'b1) begin errors++; $display("FAIL pause_kept: got %b expected 1", paused); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (paused !== 1'b0) begin errors++; $display("FAIL pause_reset: got %b expected 0", paused); end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef BLINK_PAUSE_EN
        test_bounce();
        test_pause();
        test_reset_mid();
`else
        test_clean_press();
        test_bounce();
        test_wrap();
        test_collision();
        test_random();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
